// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared source encodings, arbiter state and priority helpers
//
// Contents:
//   SRC_PS2 / SRC_IR / SRC_NES  source encodings driven on Choice
//   arb_state_t                 arbiter state (IDLE: no owner, OWN: one source granted)
//   PRIO_ORDER                  packed priority list, slot 0 = highest priority
//   highest_active()            pick the highest-priority active source
//   map_manual()                fold ManualChoice onto the legal Choice set

package input_pkg;

    localparam logic [1:0] SRC_PS2 = 2'd0;
    localparam logic [1:0] SRC_IR  = 2'd1;
    localparam logic [1:0] SRC_NES = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Slot 0 (bits 1:0) is the highest priority: NES, then PS/2, then IR.
    localparam logic [5:0] PRIO_ORDER = {SRC_IR, SRC_PS2, SRC_NES};

    // act is indexed by source encoding; bit 3 is never a real source.
    // Walks from lowest to highest priority so the highest active one wins.
    function automatic logic [1:0] highest_active(input logic [3:0] act);
        logic [1:0] sel;
        logic [1:0] cand;
        sel = SRC_NES;
        for (int i = 2; i >= 0; i--) begin
            cand = PRIO_ORDER[2*i +: 2];
            if (act[cand]) begin
                sel = cand;
            end
        end
        return sel;
    endfunction

    // Codes 2 and 3 both mean the NES/SNES port.
    function automatic logic [1:0] map_manual(input logic [1:0] req);
        return (req == 2'd3) ? SRC_NES : req;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// rtl/idle_timer.sv - saturating inactivity counter with terminal-count flag
//
// Ports:
//   clk     in  system clock
//   clear   in  synchronous clear, dominant over enable
//   enable  in  advance the count by one (holds at the terminal value)
//   tc      out count has reached TIMEOUT_CYCLES-1

module idle_timer #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/input_source_arbiter.sv
// rtl/input_source_arbiter.sv - grants one of PS/2, IR, NES to the input decoder
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   Manual, ManualChoice      manual source selection (3 maps to NES)
//   PDir/IDir/NDir            {Up,Down,Left,Right} per source
//   PReadable/IReadable/NReadable  per-source data valid
//   Choice                    registered source select (0 PS/2, 1 IR, 2 NES)
//   Owned                     registered, a source currently holds the grant
//   Switched                  registered one-cycle pulse when Choice changes

module input_source_arbiter
    import input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Manual,
    input  logic [1:0] ManualChoice,
    input  logic [3:0] PDir,
    input  logic [3:0] IDir,
    input  logic [3:0] NDir,
    input  logic       PReadable,
    input  logic       IReadable,
    input  logic       NReadable,
    output logic [1:0] Choice,
    output logic       Owned,
    output logic       Switched
);

    arb_state_t state;

    // Both vectors are indexed by source encoding so Choice selects directly.
    logic [3:0] readable;
    logic [3:0] active;

    assign readable = {1'b0, NReadable, IReadable, PReadable};
    assign active   = readable & {1'b0, |NDir, |IDir, |PDir};

    logic       any_active;
    logic [1:0] grant_src;
    logic [1:0] manual_src;
    logic       owner_readable;
    logic       owner_active;

    assign any_active     = |active;
    assign grant_src      = highest_active(active);
    assign manual_src     = map_manual(ManualChoice);
    assign owner_readable = readable[Choice];
    assign owner_active   = active[Choice];

    // The timer only runs while an owner is present, readable and idle.
    // Hitting terminal count clears it on the same edge the grant is dropped.
    logic timing;
    logic timer_tc;

    assign timing = !Manual && (state == ST_OWN) && owner_readable && !owner_active;

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (CLK),
        .clear  (RST || !timing || timer_tc),
        .enable (timing),
        .tc     (timer_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            Choice   <= SRC_NES;
            Owned    <= 1'b0;
            Switched <= 1'b0;
        end else begin
            Switched <= 1'b0;
            if (Manual) begin
                // Manual mode keeps the FSM parked so leaving it starts a
                // fresh arbitration round from IDLE.
                state    <= ST_IDLE;
                Choice   <= manual_src;
                Owned    <= readable[manual_src];
                Switched <= (manual_src != Choice);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_active) begin
                            state    <= ST_OWN;
                            Choice   <= grant_src;
                            Owned    <= 1'b1;
                            Switched <= (grant_src != Choice);
                        end else begin
                            Owned <= 1'b0;
                        end
                    end
                    ST_OWN: begin
                        // No pre-emption: other sources are not looked at
                        // until the owner lets go and one IDLE cycle passes.
                        if (!owner_readable) begin
                            state <= ST_IDLE;
                            Owned <= 1'b0;
                        end else if (!owner_active && timer_tc) begin
                            state <= ST_IDLE;
                            Owned <= 1'b0;
                        end else begin
                            Owned <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        Owned <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_input_source_arbiter.sv
// tb/tb_input_source_arbiter.sv - self-checking bench for input_source_arbiter

module tb_input_source_arbiter;

    localparam int T = 8;
    localparam int PRIO [3] = '{2, 0, 1};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Manual = 1'b0;
    logic [1:0] ManualChoice = 2'd0;
    logic [3:0] PDir = 4'd0;
    logic [3:0] IDir = 4'd0;
    logic [3:0] NDir = 4'd0;
    logic       PReadable = 1'b0;
    logic       IReadable = 1'b0;
    logic       NReadable = 1'b0;
    logic [1:0] Choice;
    logic       Owned;
    logic       Switched;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    input_source_arbiter #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Manual       (Manual),
        .ManualChoice (ManualChoice),
        .PDir         (PDir),
        .IDir         (IDir),
        .NDir         (NDir),
        .PReadable    (PReadable),
        .IReadable    (IReadable),
        .NReadable    (NReadable),
        .Choice       (Choice),
        .Owned        (Owned),
        .Switched     (Switched)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int         m_owner  = -1;
    int         m_cnt    = 0;
    logic [1:0] m_choice = 2'd2;
    logic       m_owned  = 1'b0;
    logic       m_sw     = 1'b0;

    function automatic bit src_rd(int s);
        case (s)
            0:       return PReadable;
            1:       return IReadable;
            default: return NReadable;
        endcase
    endfunction

    function automatic bit src_act(int s);
        case (s)
            0:       return PReadable && (PDir != 4'd0);
            1:       return IReadable && (IDir != 4'd0);
            default: return NReadable && (NDir != 4'd0);
        endcase
    endfunction

    always @(posedge CLK) begin : model
        int         n_owner;
        int         n_cnt;
        int         sel;
        logic [1:0] n_choice;
        logic       n_owned;
        n_owner  = m_owner;
        n_cnt    = m_cnt;
        n_choice = m_choice;
        n_owned  = m_owned;
        if (RST) begin
            n_owner = -1; n_cnt = 0; n_choice = 2'd2; n_owned = 1'b0;
        end else if (Manual) begin
            sel = (ManualChoice == 2'd3) ? 2 : int'(ManualChoice);
            n_owner = -1; n_cnt = 0; n_choice = 2'(sel); n_owned = src_rd(sel);
        end else if (m_owner < 0) begin
            n_owned = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (src_act(PRIO[i])) begin
                    n_owner = PRIO[i]; n_choice = 2'(PRIO[i]); n_owned = 1'b1; n_cnt = 0;
                    break;
                end
            end
        end else if (!src_rd(m_owner)) begin
            n_owner = -1; n_owned = 1'b0; n_cnt = 0;
        end else if (src_act(m_owner)) begin
            n_cnt = 0;
        end else if (m_cnt == T - 1) begin
            n_owner = -1; n_owned = 1'b0; n_cnt = 0;
        end else begin
            n_cnt = m_cnt + 1;
        end
        m_sw     <= !RST && (n_choice != m_choice);
        m_owner  <= n_owner;
        m_cnt    <= n_cnt;
        m_choice <= n_choice;
        m_owned  <= n_owned;
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            vectors++;
            if (Choice !== m_choice || Owned !== m_owned || Switched !== m_sw) begin
                miscompares++;
                $display("FAIL model t=%0t: Choice=%0d Owned=%0d Switched=%0d, expected %0d %0d %0d",
                         $time, Choice, Owned, Switched, m_choice, m_owned, m_sw);
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [1:0] ec, input logic eo, input logic es);
        vectors++;
        if (Choice !== ec || Owned !== eo || Switched !== es) begin
            miscompares++;
            $display("FAIL %s: Choice=%0d Owned=%0d Switched=%0d, expected %0d %0d %0d",
                     name, Choice, Owned, Switched, ec, eo, es);
        end
    endtask

    initial begin
        // Reset with every source active
        PReadable = 1; IReadable = 1; NReadable = 1;
        PDir = 4'b1000; IDir = 4'b0100; NDir = 4'b0010;
        step(); chk_en = 1'b1;
        chk("rst_cycle1", 2, 0, 0);
        step(); chk("rst_cycle2", 2, 0, 0);
        RST = 0;
        step(); chk("nes_after_rst", 2, 1, 0);

        // PS/2 and NES active on the same edge from IDLE
        RST = 1; PReadable = 0; IReadable = 0; NReadable = 0;
        PDir = 0; IDir = 0; NDir = 0;
        step(); chk("rst_again", 2, 0, 0);
        RST = 0; PReadable = 1; PDir = 4'b1000; NReadable = 1; NDir = 4'b0010;
        step(); chk("p_n_same_edge", 2, 1, 0);
        NReadable = 0; PReadable = 0;
        step(); chk("nes_unreadable", 2, 0, 0);

        // PS/2 owner times out, IR picked up one edge later
        PReadable = 1; PDir = 4'b1000; IReadable = 1; IDir = 4'b0100;
        step(); chk("ps2_grant", 0, 1, 1);
        PDir = 0;
        repeat (7) step();
        chk("ps2_7_idle", 0, 1, 0);
        step(); chk("ps2_timeout", 0, 0, 0);
        step(); chk("ir_grant", 1, 1, 1);
        step(); chk("ir_hold", 1, 1, 0);

        // IR owner is not pre-empted; its loss of Readable releases
        PDir = 4'b1000;
        step(); chk("no_preempt1", 1, 1, 0);
        step(); chk("no_preempt2", 1, 1, 0);
        IReadable = 0;
        step(); chk("ir_drop", 1, 0, 0);
        step(); chk("ps2_regrant", 0, 1, 1);

        // Activity part-way through the idle count restarts it
        PDir = 0;
        repeat (5) step();
        PDir = 4'b0001;
        step(); chk("activity", 0, 1, 0);
        PDir = 0;
        repeat (7) step();
        chk("timer_restart", 0, 1, 0);
        step(); chk("timeout2", 0, 0, 0);
        step(); chk("idle_hold", 0, 0, 0);

        // Manual selection
        Manual = 1; ManualChoice = 2'd3; NReadable = 1;
        step(); chk("man3", 2, 1, 1);
        ManualChoice = 2'd0; PReadable = 1;
        step(); chk("man0", 0, 1, 1);
        PReadable = 0;
        step(); chk("man0_unrd", 0, 0, 0);
        ManualChoice = 2'd1;
        step(); chk("man1", 1, 0, 1);
        Manual = 0; NReadable = 0;
        step(); chk("man_exit_idle", 1, 0, 0);
        PReadable = 1; PDir = 4'b0100;
        step(); chk("auto_resume", 0, 1, 1);

        // Reset in the middle of an idle count
        PDir = 0;
        repeat (5) step();
        chk("pre_rst", 0, 1, 0);
        RST = 1;
        step(); chk("rst_mid_own", 2, 0, 0);
        RST = 0;
        step(); chk("post_rst_idle", 2, 0, 0);
        PDir = 4'b1000;
        step(); chk("post_rst_grant", 0, 1, 1);
        step(); chk("post_rst_hold", 0, 1, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_source_arbiter.md
INPUT_SOURCE_ARBITER -- requirements
Module: input_source_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8 (sim) / 25_000_000 (board), inactive cycles before the owner is released; legal range >= 2.
REQ-002 CLK  in  1  system clock; all state changes on posedge CLK.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 Manual  in  1  1 = manual source selection; 0 = automatic arbitration.
REQ-005 ManualChoice  in  2  source requested in manual mode (0 PS/2, 1 IR, 2/3 NES/SNES).
REQ-006 PDir / IDir / NDir  in  4 each  per-source direction bits {Up,Down,Left,Right}.
REQ-007 PReadable / IReadable / NReadable  in  1 each  source data valid.
REQ-008 Choice  out  2  registered source select driven to the input decoder; value set {0,1,2} only.
REQ-009 Owned  out  1  registered; 1 when a source currently holds the grant.
REQ-010 Switched  out  1  registered one-cycle pulse whenever Choice changes value.

Function
REQ-011 Source active = Readable AND (OR of its 4 Dir bits); computed combinationally from current inputs.
REQ-012 States: IDLE (no owner) and OWN (one source granted); Choice and owner register are identical.
REQ-013 IDLE, Manual=0: if any source active, grant the highest-priority active source (NES > PS/2 > IR), load Choice, set Owned=1, clear timer, go OWN on the same edge.
REQ-014 IDLE, no source active: hold Choice at last value, Owned=0.
REQ-015 OWN, owner active: clear timer, stay OWN; other sources ignored (no pre-emption).
REQ-016 OWN, owner Readable=0: release on that edge -> IDLE, Owned=0, Choice held.
REQ-017 OWN, owner Readable=1 but idle: increment timer; on the edge where timer equals TIMEOUT_CYCLES-1 -> IDLE, Owned=0, timer cleared.
REQ-018 Release and re-grant never occur on the same edge; a new grant needs at least one cycle in IDLE.
REQ-019 Timer width = clog2(TIMEOUT_CYCLES); timer saturates, never wraps.
REQ-020 Manual=1: state forced to IDLE, timer cleared, Choice = ManualChoice with 3 mapped to 2, Owned = Readable of the selected source, registered (1-cycle latency).
REQ-021 Manual 1->0: arbitration resumes from IDLE on the next edge; Choice held until a grant.
REQ-022 Switched=1 for exactly one cycle, the cycle after the edge on which Choice's value changed; re-granting the same source gives no pulse.
REQ-023 Latency: input change sampled at edge k is visible on Choice/Owned after edge k.

Reset
REQ-024 RST=1 at a clock edge: state IDLE, Choice=2, Owned=0, Switched=0, timer=0; overrides all other inputs, including mid-OWN and mid-timeout.
REQ-025 First edge after RST deasserts is a normal arbitration edge.

Structure
REQ-026 Shared package input_pkg: source encoding constants SRC_PS2=0, SRC_IR=1, SRC_NES=2; arbiter state enum; priority order constant.
REQ-027 One sub-module: idle_timer (clear, enable, saturating count, terminal-count flag), parameterised by TIMEOUT_CYCLES.
REQ-028 Choice connects directly to the Choice input of the input decoder; no other decoder changes.

Verification (TIMEOUT_CYCLES=8)
REQ-029 RST for 2 cycles with all sources active -> Choice=2, Owned=0, Switched=0 throughout; after release, NES granted next edge.
REQ-030 IDLE, PDir=4'b1000 and NDir=4'b0010 active on the same edge -> Choice=2, Owned=1, no Switched pulse (already 2).
REQ-031 PS/2 owns, PDir=0 with PReadable=1 for 8 cycles -> Owned=0 after 8th edge; IR active throughout -> Choice=1 one edge later, Switched pulse 1 cycle.
REQ-032 IR owns, PS/2 becomes active -> Choice stays 1; IReadable drops -> Owned=0 same edge, PS/2 granted next edge.
REQ-033 Manual=1, ManualChoice=3 -> Choice=2; ManualChoice=0 -> Choice=0 next edge, Switched 1 cycle, Owned=PReadable.
REQ-034 RST asserted at timer=5 during OWN -> timer=0, IDLE, Choice=2 on that edge.
